// File: rtl/interact.sv
// Shared link types, flit field positions and port numbering for the 5-port mesh router.
package interact;

   localparam int LINK_WIDTH = 35;
   localparam int NUM_PORTS  = 5;

   localparam int FLIT_VALID = 34;
   localparam int FLIT_HEAD  = 33;
   localparam int FLIT_TAIL  = 32;
   localparam int DEST_X_HI  = 31;
   localparam int DEST_X_LO  = 27;
   localparam int DEST_Y_HI  = 26;
   localparam int DEST_Y_LO  = 22;

   typedef enum logic [2:0] {
      PORT_LOCAL = 3'd0,
      PORT_NORTH = 3'd1,
      PORT_EAST  = 3'd2,
      PORT_SOUTH = 3'd3,
      PORT_WEST  = 3'd4
   } port_e;

   typedef struct packed {
      logic [LINK_WIDTH-1:0] data;
   } link_f_t;

   typedef struct packed {
      logic ready;
   } link_b_t;

   typedef link_f_t [NUM_PORTS-1:0] router_port_f;
   typedef link_b_t [NUM_PORTS-1:0] router_port_b;

endpackage

// File: rtl/input_buffer.sv
// Synchronous flit FIFO with first-word-fall-through read; DEPTH must be a power of 2.
module input_buffer
   import interact::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [LINK_WIDTH-1:0]   wr_data,
   input  logic                    rd_en,
   output logic [LINK_WIDTH-1:0]   rd_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);

   logic [LINK_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wptr;
   logic [AW-1:0]         rptr;
   logic                  do_wr;
   logic                  do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= wr_data;
   end

endmodule

// File: rtl/router.sv
// 5-port wormhole mesh router: per-input FIFOs, XY routing, per-output round-robin
// arbitration with packet locks, and a registered crossbar output stage.
module router
   import interact::*;
#(
   parameter logic [4:0] ROUTER_X  = 5'd0,
   parameter logic [4:0] ROUTER_Y  = 5'd0,
   parameter int         BUF_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  router_port_f inPort_f,
   output router_port_b inPort_b,
   output router_port_f outPort_f,
   input  router_port_b outPort_b
);

   localparam int NP     = NUM_PORTS;
   localparam int CW     = $clog2(BUF_DEPTH) + 1;
   localparam int XSEL_W = NP * (NP - 1);

   logic [LINK_WIDTH-1:0] head_flit [NP];
   logic [CW-1:0]         fifo_count [NP];
   logic [NP-1:0]         fifo_empty, fifo_full, wr_en, rd_en;
   logic [NP-1:0]         nonempty, is_head, active, moved, drop;
   logic [2:0]            dir [NP];
   logic [NP-1:0]         req [NP];
   logic [NP-1:0]         grant_oh [NP];
   logic [NP-1:0]         new_grant, out_space;
   logic [2:0]            gnt_idx [NP];
   logic [XSEL_W-1:0]     xbar_sel;
   logic [LINK_WIDTH-1:0] sel_flit [NP];
   logic [2:0]            arb_idx;
   logic                  unused_count;

   logic [NP-1:0]         lock_q;
   logic [2:0]            owner_q [NP];
   logic [2:0]            rr_q [NP];
   logic [LINK_WIDTH-1:0] out_q [NP];

   function automatic port_e xy_route(input logic [4:0] dx, input logic [4:0] dy);
      if (dx > ROUTER_X)      return PORT_EAST;
      else if (dx < ROUTER_X) return PORT_WEST;
      else if (dy > ROUTER_Y) return PORT_NORTH;
      else if (dy < ROUTER_Y) return PORT_SOUTH;
      else                    return PORT_LOCAL;
   endfunction

   for (genvar g = 0; g < NP; g++) begin : g_buf
      input_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_en[g]),
         .wr_data (inPort_f[g].data),
         .rd_en   (rd_en[g]),
         .rd_data (head_flit[g]),
         .full    (fifo_full[g]),
         .empty   (fifo_empty[g]),
         .count   (fifo_count[g])
      );
   end

   always_comb begin
      unused_count = 1'b0;
      for (int i = 0; i < NP; i++) begin
         inPort_b[i].ready  = !fifo_full[i] && !reset;
         wr_en[i]           = inPort_f[i].data[FLIT_VALID] && !fifo_full[i] && !reset;
         outPort_f[i].data  = out_q[i];
         nonempty[i]        = !fifo_empty[i];
         is_head[i]         = head_flit[i][FLIT_HEAD];
         dir[i]             = xy_route(head_flit[i][DEST_X_HI:DEST_X_LO],
                                       head_flit[i][DEST_Y_HI:DEST_Y_LO]);
         unused_count       = unused_count ^ (^fifo_count[i]);
      end
   end

   // Locked outputs follow their owner; free outputs arbitrate among head flits.
   always_comb begin
      active  = '0;
      arb_idx = '0;
      for (int o = 0; o < NP; o++)
         for (int i = 0; i < NP; i++)
            if (lock_q[o] && owner_q[o] == 3'(i)) active[i] = 1'b1;

      for (int i = 0; i < NP; i++)
         drop[i] = nonempty[i] && !active[i] && (!is_head[i] || dir[i] == 3'(i));

      for (int o = 0; o < NP; o++) begin
         out_space[o] = !out_q[o][FLIT_VALID] || outPort_b[o].ready;
         req[o]       = '0;
         grant_oh[o]  = '0;
         new_grant[o] = 1'b0;
         gnt_idx[o]   = '0;
         for (int i = 0; i < NP; i++)
            req[o][i] = (i != o) && nonempty[i] && !active[i] && is_head[i] &&
                        (dir[i] == 3'(o));
         if (lock_q[o]) begin
            for (int i = 0; i < NP; i++)
               if (owner_q[o] == 3'(i) && nonempty[i] && out_space[o]) grant_oh[o][i] = 1'b1;
         end else if (out_space[o]) begin
            for (int k = 0; k < NP; k++) begin
               arb_idx = 3'((int'(rr_q[o]) + k) % NP);
               if (!new_grant[o] && req[o][arb_idx]) begin
                  grant_oh[o][arb_idx] = 1'b1;
                  gnt_idx[o]           = arb_idx;
                  new_grant[o]         = 1'b1;
               end
            end
         end
      end
   end

   // Crossbar select: slot k of output o names the k-th input after skipping o itself.
   always_comb begin
      xbar_sel = '0;
      moved    = '0;
      for (int o = 0; o < NP; o++) begin
         sel_flit[o] = '0;
         for (int k = 0; k < NP - 1; k++) begin
            xbar_sel[o*(NP-1)+k] = grant_oh[o][(k < o) ? k : k + 1];
            if (xbar_sel[o*(NP-1)+k])
               sel_flit[o] = sel_flit[o] | head_flit[(k < o) ? k : k + 1];
         end
         for (int i = 0; i < NP; i++)
            if (grant_oh[o][i]) moved[i] = 1'b1;
      end
      rd_en = moved | drop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q <= '0;
         for (int o = 0; o < NP; o++) begin
            owner_q[o] <= '0;
            rr_q[o]    <= '0;
            out_q[o]   <= '0;
         end
      end else begin
         for (int o = 0; o < NP; o++) begin
            if (|grant_oh[o])
               out_q[o] <= sel_flit[o];
            else if (out_q[o][FLIT_VALID] && outPort_b[o].ready)
               out_q[o] <= '0;

            if (new_grant[o]) begin
               rr_q[o] <= (gnt_idx[o] == 3'(NP - 1)) ? 3'd0 : gnt_idx[o] + 3'd1;
               if (!sel_flit[o][FLIT_TAIL]) begin
                  lock_q[o]  <= 1'b1;
                  owner_q[o] <= gnt_idx[o];
               end
            end else if (lock_q[o] && (|grant_oh[o]) && sel_flit[o][FLIT_TAIL]) begin
               lock_q[o] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_router.sv
// Bench for router (0,0): queue-level reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized traffic phase.
module tb_router;
   import interact::*;

   localparam int DEPTH = 4;
   localparam int RX    = 0;
   localparam int RY    = 0;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   router_port_f in_f;
   router_port_f out_f;
   router_port_b in_b;
   router_port_b out_b;

   always #5 clk = ~clk;

   router #(.ROUTER_X(5'd0), .ROUTER_Y(5'd0), .BUF_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .inPort_f  (in_f),
      .inPort_b  (in_b),
      .outPort_f (out_f),
      .outPort_b (out_b)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   // reference model state
   logic [34:0] mq [5][$];
   int          lock_own [5];
   int          rr [5];
   logic [34:0] mreg [5];
   bit          acc [5];
   bit          s_rst;
   logic [34:0] s_in [5];
   bit          s_rdy [5];
   logic [34:0] d_out2 = '0;
   logic [34:0] elog [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got=%0h want=%0h", name, act, exp);
   endtask

   function automatic int route(input logic [34:0] f);
      int dx, dy;
      dx = int'(f[31:27]);
      dy = int'(f[26:22]);
      if (dx > RX) return 2;
      if (dx < RX) return 4;
      if (dy > RY) return 1;
      if (dy < RY) return 3;
      return 0;
   endfunction

   function automatic logic [34:0] fl(input bit h, input bit t, input logic [31:0] p);
      return {1'b1, h, t, p};
   endfunction

   function automatic logic [31:0] hp(input int dx, input int dy, input int id);
      return {5'(dx), 5'(dy), 22'(id)};
   endfunction

   task automatic model_step();
      int take [5];
      bit busy [5];
      int psz [5];
      bit sp, pop;
      int i;
      logic [34:0] f;
      if (s_rst) begin
         for (int p = 0; p < 5; p++) begin
            mq[p].delete();
            lock_own[p] = -1;
            rr[p]       = 0;
            mreg[p]     = '0;
            acc[p]      = 1'b0;
         end
         return;
      end
      for (int p = 0; p < 5; p++) begin
         busy[p] = 1'b0;
         psz[p]  = mq[p].size();
      end
      for (int o = 0; o < 5; o++) if (lock_own[o] >= 0) busy[lock_own[o]] = 1'b1;
      for (int o = 0; o < 5; o++) begin
         take[o] = -1;
         sp = !mreg[o][34] || s_rdy[o];
         if (lock_own[o] >= 0) begin
            if (psz[lock_own[o]] > 0 && sp) take[o] = lock_own[o];
         end else if (sp) begin
            for (int k = 0; k < 5; k++) begin
               i = (rr[o] + k) % 5;
               if (take[o] < 0 && i != o && psz[i] > 0 && !busy[i] &&
                   mq[i][0][33] && route(mq[i][0]) == o) take[o] = i;
            end
         end
      end
      for (int o = 0; o < 5; o++) begin
         if (take[o] >= 0) begin
            f = mq[take[o]][0];
            mreg[o] = f;
            if (lock_own[o] < 0) begin
               rr[o] = (take[o] + 1) % 5;
               if (!f[32]) lock_own[o] = take[o];
            end else if (f[32]) begin
               lock_own[o] = -1;
            end
         end else if (mreg[o][34] && s_rdy[o]) begin
            mreg[o] = '0;
         end
      end
      for (int p = 0; p < 5; p++) begin
         pop = 1'b0;
         for (int o = 0; o < 5; o++) if (take[o] == p) pop = 1'b1;
         if (!pop && psz[p] > 0 && !busy[p] && (!mq[p][0][33] || route(mq[p][0]) == p)) pop = 1'b1;
         if (pop) void'(mq[p].pop_front());
      end
      for (int p = 0; p < 5; p++) begin
         acc[p] = s_in[p][34] && (psz[p] < DEPTH);
         if (acc[p]) mq[p].push_back(s_in[p]);
      end
   endtask

   // compare process: capture stable inputs at the edge, advance the model, check after
   initial begin
      for (int p = 0; p < 5; p++) begin
         lock_own[p] = -1;
         rr[p]       = 0;
         mreg[p]     = '0;
         acc[p]      = 1'b0;
      end
      forever begin
         @(posedge clk);
         s_rst = reset;
         for (int p = 0; p < 5; p++) begin
            s_in[p]  = in_f[p].data;
            s_rdy[p] = out_b[p].ready;
         end
         if (d_out2[34] && s_rdy[2] && !s_rst) elog.push_back(d_out2);
         model_step();
         #1;
         d_out2 = out_f[2].data;
         if (chk_en) begin
            for (int p = 0; p < 5; p++) begin
               check($sformatf("out%0d", p), 64'(out_f[p].data), 64'(mreg[p]));
               check($sformatf("rdy%0d", p), 64'(in_b[p].ready),
                     64'(!reset && (mq[p].size() < DEPTH)));
            end
         end
      end
   end

   task automatic idle_in();
      for (int p = 0; p < 5; p++) in_f[p].data = '0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_in();
      cyc(3);
      reset = 1'b0;
   endtask

   task automatic check_log(input string name, input logic [34:0] exp [], input int n);
      check({name, "_cnt"}, 64'(elog.size()), 64'(n));
      for (int k = 0; k < n; k++)
         check($sformatf("%s_%0d", name, k),
               64'((k < elog.size()) ? elog[k] : 35'h0), 64'(exp[k]));
   endtask

   logic [34:0] expv [];
   int          rem [5];
   logic [34:0] cur [5];
   int          len;

   initial begin
      reset = 1'b1;
      idle_in();
      for (int p = 0; p < 5; p++) out_b[p].ready = 1'b1;
      cyc(3);
      for (int p = 0; p < 5; p++) check($sformatf("rst_out%0d", p), 64'(out_f[p].data), 64'h0);
      check("rst_rdy", 64'(in_b), 64'h0);
      chk_en = 1'b1;
      reset  = 1'b0;
      #1 check("rdy_after_rst", 64'(in_b), 64'h1f);

      // single head from North addressed to (0,0) leaves on Local one edge after write
      in_f[1].data = {3'b110, 32'd0};
      cyc(1);
      in_f[1].data = '0;
      #1 check("lat_before", 64'(out_f[0].data), 64'h0);
      cyc(1);
      check("north_to_local", 64'(out_f[0].data), 64'h6_0000_0000);

      // Local packet to East holds the lock until its tail, then North's head follows
      do_reset();
      elog.delete();
      in_f[0].data = fl(1, 0, hp(3, 0, 'h11));
      cyc(1);
      in_f[0].data = fl(0, 0, 32'hB0D1);
      in_f[1].data = fl(1, 1, hp(3, 0, 'h22));
      cyc(1);
      in_f[0].data = fl(0, 1, 32'h7A11);
      in_f[1].data = '0;
      cyc(1);
      idle_in();
      cyc(10);
      expv = new[4];
      expv[0] = fl(1, 0, hp(3, 0, 'h11));
      expv[1] = fl(0, 0, 32'hB0D1);
      expv[2] = fl(0, 1, 32'h7A11);
      expv[3] = fl(1, 1, hp(3, 0, 'h22));
      check_log("wormhole", expv, 4);

      // North vs South contention for East, twice
      do_reset();
      elog.delete();
      in_f[1].data = fl(1, 0, hp(3, 0, 'hA0));
      in_f[3].data = fl(1, 0, hp(3, 0, 'hB0));
      cyc(1);
      in_f[1].data = fl(0, 1, 32'hA1);
      in_f[3].data = fl(0, 0, 32'hB1);
      cyc(1);
      in_f[1].data = fl(1, 1, hp(3, 0, 'hC0));
      in_f[3].data = fl(0, 1, 32'hB2);
      cyc(1);
      idle_in();
      cyc(14);
      expv = new[6];
      expv[0] = fl(1, 0, hp(3, 0, 'hA0));
      expv[1] = fl(0, 1, 32'hA1);
      expv[2] = fl(1, 0, hp(3, 0, 'hB0));
      expv[3] = fl(0, 0, 32'hB1);
      expv[4] = fl(0, 1, 32'hB2);
      expv[5] = fl(1, 1, hp(3, 0, 'hC0));
      check_log("rr", expv, 6);

      // backpressure on East: four buffered plus one held, sixth flit dropped
      do_reset();
      elog.delete();
      out_b[2].ready = 1'b0;
      expv = new[5];
      expv[0] = fl(1, 0, hp(3, 0, 0));
      expv[1] = fl(0, 0, 32'd1);
      expv[2] = fl(0, 0, 32'd2);
      expv[3] = fl(0, 0, 32'd3);
      expv[4] = fl(0, 1, 32'd4);
      for (int n = 0; n < 6; n++) begin
         in_f[0].data = (n < 5) ? expv[n] : fl(1, 1, hp(3, 0, 5));
         #1 if (n == 5) check("bp_rdy_low", 64'(in_b[0].ready), 64'h0);
         cyc(1);
      end
      idle_in();
      cyc(2);
      check("bp_rdy_still_low", 64'(in_b[0].ready), 64'h0);
      check("bp_held", 64'(out_f[2].data), 64'(expv[0]));
      out_b[2].ready = 1'b1;
      cyc(10);
      check_log("bp", expv, 5);
      check("bp_rdy_back", 64'(in_b[0].ready), 64'h1);

      // U-turn on Local is discarded whole; a later packet still gets through
      do_reset();
      elog.delete();
      in_f[0].data = fl(1, 0, hp(0, 0, 'h36));
      cyc(1);
      in_f[0].data = fl(0, 0, 32'd1);
      cyc(1);
      in_f[0].data = fl(0, 1, 32'd2);
      cyc(1);
      idle_in();
      cyc(6);
      check("uturn_none", 64'(elog.size()), 64'h0);
      for (int p = 0; p < 5; p++) check($sformatf("uturn_out%0d", p), 64'(out_f[p].data), 64'h0);
      in_f[0].data = fl(1, 1, hp(1, 0, 'h37));
      cyc(1);
      idle_in();
      cyc(5);
      expv = new[1];
      expv[0] = fl(1, 1, hp(1, 0, 'h37));
      check_log("after_uturn", expv, 1);

      // reset in the middle of a packet
      do_reset();
      in_f[0].data = fl(1, 0, hp(2, 0, 'h40));
      cyc(1);
      in_f[0].data = fl(0, 0, 32'h41);
      cyc(1);
      idle_in();
      reset = 1'b1;
      cyc(1);
      for (int p = 0; p < 5; p++) check($sformatf("midrst_out%0d", p), 64'(out_f[p].data), 64'h0);
      check("midrst_rdy", 64'(in_b), 64'h0);
      cyc(2);
      elog.delete();
      reset = 1'b0;
      #1 check("midrst_rdy_after", 64'(in_b), 64'h1f);
      in_f[0].data = fl(0, 1, 32'h42);
      cyc(1);
      idle_in();
      cyc(6);
      check("midrst_no_partial", 64'(elog.size()), 64'h0);
      for (int p = 0; p < 5; p++) check($sformatf("midrst_post%0d", p), 64'(out_f[p].data), 64'h0);

      // randomized traffic
      do_reset();
      for (int p = 0; p < 5; p++) begin
         rem[p] = 0;
         cur[p] = '0;
      end
      repeat (3000) begin
         for (int p = 0; p < 5; p++) begin
            if (cur[p][34] && acc[p]) begin
               if (rem[p] == 0) cur[p] = '0;
               else begin
                  rem[p]--;
                  cur[p] = fl(0, rem[p] == 0, $urandom);
               end
            end
            if (!cur[p][34] && $urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 29) == 0) begin
                  cur[p] = fl(0, 1'($urandom_range(0, 1)), $urandom);
                  rem[p] = 0;
               end else begin
                  len    = $urandom_range(1, 4);
                  rem[p] = len - 1;
                  cur[p] = fl(1, len == 1, hp($urandom_range(0, 2), $urandom_range(0, 2),
                                              $urandom));
               end
            end
            in_f[p].data   = cur[p];
            out_b[p].ready = ($urandom_range(0, 3) != 0);
         end
         cyc(1);
      end
      idle_in();
      for (int p = 0; p < 5; p++) out_b[p].ready = 1'b1;
      cyc(60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
